axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI-Stream packet FIFO input between NS source streams.
- Sits upstream of the store-and-forward FIFO.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted, so packets are never interleaved.
- Provides a per-source enable mask, the granted source ID, and a forwarded-packet counter for status registers.

Parameters:
- DW, 8, data width per beat.
- NS, 4, number of source streams (2..16).
- IW, $clog2(NS), width of source ID.
- CW, 16, width of packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- s_tdata  in  NS*DW  source data; source i occupies bits [i*DW +: DW].
- s_tvalid  in  NS  per-source valid.
- s_tlast  in  NS  per-source last-beat flag.
- s_tready  out  NS  per-source ready.
- m_tdata  out  DW  data to FIFO.
- m_tvalid  out  1  valid to FIFO.
- m_tlast  out  1  last-beat flag to FIFO.
- m_tready  in  1  FIFO ready.
- src_en  in  NS  source enable mask; 1 = eligible for grant.
- m_tid  out  IW  index of the currently/last granted source.
- busy  out  1  high while a packet is in flight (BUSY state).
- pkt_cnt  out  CW  count of packets forwarded (tlast handshakes on m_*).

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On a reset edge:
  - state = IDLE, rr_ptr = 0, grant = 0, m_tid = 0, busy = 0, pkt_cnt = 0.
  - m_tvalid = 0 and s_tready = all 0 in the cycle after the reset edge.
  - Reset mid-packet abandons the packet. No tlast is synthesised; downstream drops partial packets.
- States: IDLE, BUSY.
- IDLE:
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, s_tready = 0, busy = 0.
  - Request vector req = s_tvalid & src_en.
  - If req != 0, select the first set bit searching from index rr_ptr upward, wrapping modulo NS.
  - Register grant and m_tid with that index; go to BUSY.
  - Arbitration costs exactly one bubble cycle: the first beat can transfer in the cycle after the request is seen.
- BUSY:
  - Combinational pass-through of the granted source: m_tdata = s_tdata[grant], m_tvalid = s_tvalid[grant], m_tlast = s_tlast[grant].
  - s_tready[grant] = m_tready; all other s_tready bits = 0.
  - busy = 1.
  - A beat transfers when m_tvalid && m_tready.
  - On a transfer with m_tlast = 1: go to IDLE, rr_ptr = (grant + 1) mod NS, pkt_cnt increments.
  - pkt_cnt wraps at 2^CW - 1 -> 0.
- src_en changes:
  - Deasserting src_en[grant] during BUSY does not abort or stall the current packet. It only affects the next arbitration.
  - src_en = 0 blocks a source entirely; its s_tready stays 0.
- Source rules:
  - Sources must not drop tvalid mid-beat (AXI rule).
  - A source deasserting tvalid between beats simply stalls the output; the grant is held.
- Degenerate cases:
  - Single-beat packet (tvalid and tlast in first beat): legal. Occupies one BUSY cycle if m_tready = 1.
  - If no source requests, remain in IDLE indefinitely.
- m_tid holds its value in IDLE; it is updated only at the grant.
- No combinational path from s_tvalid to s_tready in IDLE.
- In BUSY, m_tready -> s_tready and s_* -> m_* are combinational; the FIFO input is registered.
- Fairness: with all NS sources continuously requesting, each source gets exactly one packet per NS grants.

Test Plan:
- Single source, NS=4: source 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with tlast), m_tready = 1 -> one IDLE bubble, m_tdata A1/A2/A3 on 3 consecutive cycles, m_tid = 2, pkt_cnt = 1, rr_ptr = 3.
- Simultaneous requests: sources 0 and 1 each hold a 2-beat packet at reset release -> source 0 packet forwarded entirely, then source 1; no interleave; pkt_cnt = 2.
- Fairness: all 4 sources stream back-to-back 1-beat packets for 16 grants -> m_tid sequence 0,1,2,3 repeated 4 times; pkt_cnt = 16.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet from source 3 -> each beat is presented until accepted; s_tready[3] equals m_tready; other s_tready bits = 0; no beat lost or duplicated.
- Mask: src_en = 4'b1010 with all sources valid -> only sources 1 and 3 granted, alternating; s_tready[0] and s_tready[2] stay 0. Clearing src_en[1] mid-packet still completes that packet.
- Reset mid-packet: assert rst during beat 2 of a 4-beat packet -> next cycle m_tvalid = 0, busy = 0, pkt_cnt = 0, m_tid = 0; a new packet from source 0 afterwards is forwarded normally.

Source files
------------

// File: rtl/axis_pkt_arbiter_if.sv
// rtl/axis_pkt_arbiter_if.sv - AXI-Stream bundle of N lanes of DW-bit beats
interface axis_pkt_arbiter_if #(
  parameter int DW = 8,
  parameter int N  = 1
);
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular round-robin arbiter of NS streams onto one FIFO input
module axis_pkt_arbiter #(
  parameter int DW = 8,
  parameter int NS = 4,
  parameter int IW = $clog2(NS),
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  axis_pkt_arbiter_if.slave   s,
  axis_pkt_arbiter_if.master  m,
  input  logic [NS-1:0]       src_en,
  output logic [IW-1:0]       m_tid,
  output logic                busy,
  output logic [CW-1:0]       pkt_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] grant_nxt;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic [NS-1:0] req;
  logic [NS-1:0] s_ready;
  logic          xfer_last;
  int            idx;
  logic [DW-1:0] src_data [NS];

  for (genvar i = 0; i < NS; i++) begin : g_lane
    assign src_data[i] = s.tdata[i*DW +: DW];
  end

  assign req       = s.tvalid & src_en;
  assign busy      = (state == BUSY);
  assign grant_nxt = (grant == IW'(NS - 1)) ? '0 : grant + IW'(1);
  assign xfer_last = busy && m.tvalid[0] && m.tready[0] && m.tlast[0];
  assign s.tready  = s_ready;

  // First requester at or after rr_ptr, wrapping; the previous winner is searched last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NS) idx = idx - NS;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // IDLE presents nothing, so a source valid never reaches its own ready combinationally.
  always_comb begin
    s_ready  = '0;
    m.tdata  = '0;
    m.tvalid = 1'b0;
    m.tlast  = 1'b0;
    if (state == BUSY) begin
      m.tdata        = src_data[grant];
      m.tvalid       = s.tvalid[grant];
      m.tlast        = s.tlast[grant];
      s_ready[grant] = m.tready[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      m_tid   <= '0;
      pkt_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant <= pick;
        m_tid <= pick;
        state <= BUSY;
      end
    end else if (xfer_last) begin
      state   <= IDLE;
      rr_ptr  <= grant_nxt;
      pkt_cnt <= pkt_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - randomized and directed bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] src_en = '1;
  logic [IW-1:0] m_tid;
  logic          busy;
  logic [CW-1:0] pkt_cnt;

  axis_pkt_arbiter_if #(.DW(DW), .N(NS)) s_bus ();
  axis_pkt_arbiter_if #(.DW(DW), .N(1))  m_bus ();

  axis_pkt_arbiter #(.DW(DW), .NS(NS), .IW(IW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (s_bus),
    .m       (m_bus),
    .src_en  (src_en),
    .m_tid   (m_tid),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sd [NS][$];
  bit         sl [NS][$];
  logic [7:0] md [NS][$];
  bit         ml [NS][$];
  bit         vld [NS];
  bit         first_b [NS];

  int         rec_tid [$];
  logic [7:0] rec_data [$];
  bit         rec_last [$];
  int         rec_cyc [$];
  int         exp_tid [$];
  logic [7:0] exp_data [$];
  bit         exp_last [$];

  int            viol;
  int            npk;
  int            model_pkts;
  bit            stall_en;
  int            rmode;
  int            chg_cyc;
  logic [NS-1:0] chg_en;
  bit            timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_bus.tvalid = '0;
    s_bus.tlast = '0;
    s_bus.tdata = '0;
    m_bus.tready = 1'b0;
    src_en = '1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_engine();
    for (int i = 0; i < NS; i++) begin
      sd[i].delete();
      sl[i].delete();
      vld[i] = 1'b0;
      first_b[i] = 1'b1;
    end
    rec_tid.delete(); rec_data.delete(); rec_last.delete(); rec_cyc.delete();
    exp_tid.delete(); exp_data.delete(); exp_last.delete();
    viol = 0; npk = 0; stall_en = 1'b0; rmode = 0; chg_cyc = -1; chg_en = '1;
  endtask

  // base < 0 gives random payload, otherwise base, base+1, ...
  task automatic push_pkt(input int src, input int len, input int base);
    for (int b = 0; b < len; b++) begin
      sd[src].push_back(base < 0 ? 8'($urandom) : 8'(base + b));
      sl[src].push_back(b == len - 1);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (sd[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected output: whole packets, round-robin over sources that still hold data.
  task automatic build_model(input int rr0);
    int ptr;
    int win;
    logic [7:0] d;
    bit l;
    ptr = rr0;
    model_pkts = 0;
    for (int i = 0; i < NS; i++) begin
      md[i] = sd[i];
      ml[i] = sl[i];
    end
    forever begin
      win = -1;
      for (int k = 0; k < NS; k++)
        if (win < 0 && md[(ptr + k) % NS].size() != 0) win = (ptr + k) % NS;
      if (win < 0) break;
      do begin
        d = md[win].pop_front();
        l = ml[win].pop_front();
        exp_tid.push_back(win);
        exp_data.push_back(d);
        exp_last.push_back(l);
      end while (!l);
      ptr = (win + 1) % NS;
      model_pkts++;
    end
  endtask

  // Drives sources from sd/sl and records every output beat; stops on drained queues or stop_pkts packets.
  task automatic run(input int max_cyc, input int stop_pkts);
    int cyc;
    logic [NS-1:0] exp_rdy;
    cyc = 0;
    timed_out = 1'b1;
    while (cyc < max_cyc) begin
      if (cyc == chg_cyc) src_en = chg_en;
      for (int i = 0; i < NS; i++) begin
        if (sd[i].size() != 0) begin
          if (!vld[i]) vld[i] = first_b[i] || !stall_en || ($urandom_range(0, 2) != 0);
          s_bus.tvalid[i] = vld[i];
          s_bus.tdata[i*DW +: DW] = vld[i] ? sd[i][0] : 8'($urandom);
          s_bus.tlast[i] = vld[i] && sl[i][0];
        end else begin
          s_bus.tvalid[i] = 1'b0;
          s_bus.tlast[i] = 1'b0;
          s_bus.tdata[i*DW +: DW] = 8'($urandom);
        end
      end
      m_bus.tready[0] = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = busy ? (NS'(m_bus.tready[0]) << m_tid) : '0;
      if (s_bus.tready !== exp_rdy) viol++;
      if (busy && (m_bus.tvalid[0] !== s_bus.tvalid[m_tid])) viol++;
      if (!busy && (m_bus.tvalid[0] !== 1'b0)) viol++;
      if (m_bus.tvalid[0] && m_bus.tready[0]) begin
        rec_tid.push_back(int'(m_tid));
        rec_data.push_back(m_bus.tdata);
        rec_last.push_back(m_bus.tlast[0]);
        rec_cyc.push_back(cyc);
        if (m_bus.tlast[0]) npk++;
      end
      for (int i = 0; i < NS; i++) begin
        if (s_bus.tvalid[i] && s_bus.tready[i]) begin
          first_b[i] = sl[i][0];
          void'(sd[i].pop_front());
          void'(sl[i].pop_front());
          vld[i] = 1'b0;
        end
      end
      tick();
      cyc++;
      if (stop_pkts > 0 ? (npk >= stop_pkts) : all_empty()) begin
        timed_out = 1'b0;
        break;
      end
    end
    s_bus.tvalid = '0;
    s_bus.tlast = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_bus.tvalid = '1;
    s_bus.tlast = '1;
    m_bus.tready = 1'b1;
    src_en = '1;
    tick();
    tick();
    checks++; if (m_bus.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b want 0", m_bus.tvalid); end
    checks++; if (s_bus.tready !== '0) begin errors++; $display("FAIL reset_s_tready: got %b want 0000", s_bus.tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (m_tid !== '0) begin errors++; $display("FAIL reset_m_tid: got %0d want 0", m_tid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_bus.tready !== '0 || m_bus.tvalid !== 1'b0) begin
      errors++; $display("FAIL idle_no_comb_path: got s_tready=%b m_tvalid=%b want 0000/0", s_bus.tready, m_bus.tvalid);
    end
  endtask

  task automatic test_single_source();
    do_reset(); clear_engine();
    push_pkt(2, 3, 8'hA1);
    run(50, 0);
    checks++; if (timed_out || rec_data.size() != 3) begin errors++; $display("FAIL single_count: got %0d beats timeout=%0d want 3", rec_data.size(), timed_out); end
    for (int k = 0; k < rec_data.size() && k < 3; k++) begin
      checks++;
      if (rec_tid[k] != 2 || rec_data[k] !== 8'(8'hA1 + k) || rec_last[k] != (k == 2) || rec_cyc[k] != k + 1) begin
        errors++;
        $display("FAIL single_beat%0d: got tid=%0d data=%h last=%0d cyc=%0d want tid=2 data=%h last=%0d cyc=%0d",
                 k, rec_tid[k], rec_data[k], rec_last[k], rec_cyc[k], 8'(8'hA1 + k), (k == 2), k + 1);
      end
    end
    checks++; if (m_tid !== 2'd2 || pkt_cnt !== 16'd1) begin errors++; $display("FAIL single_status: got tid=%0d cnt=%0d want 2/1", m_tid, pkt_cnt); end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_ready: got %0d violations want 0", viol); end
    // Pointer now sits at 3, so source 3 must beat source 0.
    clear_engine();
    push_pkt(0, 1, 8'h10);
    push_pkt(3, 1, 8'h30);
    run(50, 0);
    checks++; if (timed_out || rec_tid.size() != 2 || rec_tid[0] != 3 || rec_tid[1] != 0) begin
      errors++; $display("FAIL rr_after_2: got %0d grants first=%0d want 3 then 0", rec_tid.size(), rec_tid.size() > 0 ? rec_tid[0] : -1);
    end
  endtask

  task automatic test_simultaneous();
    int et[4] = '{0, 0, 1, 1};
    int ed[4] = '{8'h10, 8'h11, 8'h20, 8'h21};
    do_reset(); clear_engine();
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20);
    run(50, 0);
    checks++; if (timed_out || rec_data.size() != 4) begin errors++; $display("FAIL simul_count: got %0d beats want 4", rec_data.size()); end
    for (int k = 0; k < rec_data.size() && k < 4; k++) begin
      checks++;
      if (rec_tid[k] != et[k] || rec_data[k] !== 8'(ed[k]) || rec_last[k] != (k % 2 == 1)) begin
        errors++; $display("FAIL simul_beat%0d: got tid=%0d data=%h want tid=%0d data=%h", k, rec_tid[k], rec_data[k], et[k], 8'(ed[k]));
      end
    end
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL simul_pkt_cnt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_fairness();
    do_reset(); clear_engine();
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < 4; r++) push_pkt(s, 1, s * 16 + r);
    run(200, 0);
    checks++; if (timed_out || rec_tid.size() != 16) begin errors++; $display("FAIL fair_count: got %0d grants want 16", rec_tid.size()); end
    for (int k = 0; k < rec_tid.size() && k < 16; k++) begin
      checks++;
      if (rec_tid[k] != k % 4 || rec_data[k] !== 8'((k % 4) * 16 + k / 4) || !rec_last[k]) begin
        errors++; $display("FAIL fair_grant%0d: got tid=%0d data=%h want tid=%0d data=%h", k, rec_tid[k], rec_data[k], k % 4, 8'((k % 4) * 16 + k / 4));
      end
    end
    checks++; if (pkt_cnt !== 16'd16 || viol != 0) begin errors++; $display("FAIL fair_status: got cnt=%0d viol=%0d want 16/0", pkt_cnt, viol); end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_engine();
    push_pkt(3, 4, 8'h40);
    rmode = 1;
    run(50, 0);
    checks++; if (timed_out || rec_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d beats want 4", rec_data.size()); end
    for (int k = 0; k < rec_data.size() && k < 4; k++) begin
      checks++;
      if (rec_tid[k] != 3 || rec_data[k] !== 8'(8'h40 + k) || rec_cyc[k] != 2 * k + 2 || rec_last[k] != (k == 3)) begin
        errors++; $display("FAIL bp_beat%0d: got tid=%0d data=%h cyc=%0d want tid=3 data=%h cyc=%0d", k, rec_tid[k], rec_data[k], rec_cyc[k], 8'(8'h40 + k), 2 * k + 2);
      end
    end
    checks++; if (viol != 0 || pkt_cnt !== 16'd1) begin errors++; $display("FAIL bp_ready: got viol=%0d cnt=%0d want 0/1", viol, pkt_cnt); end
  endtask

  task automatic test_mask();
    do_reset(); clear_engine();
    src_en = 4'b1010;
    for (int s = 0; s < NS; s++) begin
      push_pkt(s, 1, 8'h00 + s);
      push_pkt(s, 1, 8'h10 + s);
    end
    run(100, 4);
    checks++; if (timed_out || rec_tid.size() != 4) begin errors++; $display("FAIL mask_count: got %0d grants want 4", rec_tid.size()); end
    for (int k = 0; k < rec_tid.size() && k < 4; k++) begin
      checks++; if (rec_tid[k] != (k % 2 == 0 ? 1 : 3)) begin errors++; $display("FAIL mask_grant%0d: got %0d want %0d", k, rec_tid[k], k % 2 == 0 ? 1 : 3); end
    end
    checks++; if (viol != 0 || sd[0].size() != 2 || sd[2].size() != 2) begin
      errors++; $display("FAIL mask_blocked: got viol=%0d left0=%0d left2=%0d want 0/2/2", viol, sd[0].size(), sd[2].size());
    end
    clear_engine();
    src_en = 4'b1010;
    push_pkt(1, 3, 8'h50);
    chg_cyc = 2;
    chg_en = 4'b1000;
    run(50, 0);
    checks++; if (timed_out || rec_data.size() != 3 || rec_data[2] !== 8'h52 || !rec_last[2] || rec_tid[2] != 1) begin
      errors++; $display("FAIL mask_midpkt: got %0d beats timeout=%0d want 3 beats from source 1", rec_data.size(), timed_out);
    end
    checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL mask_pkt_cnt: got %0d want 5", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset(); clear_engine();
    push_pkt(1, 1, 8'h60);
    run(20, 0);
    checks++; if (pkt_cnt !== 16'd1 || m_tid !== 2'd1) begin errors++; $display("FAIL rstmid_pre: got cnt=%0d tid=%0d want 1/1", pkt_cnt, m_tid); end
    clear_engine();
    push_pkt(3, 4, 8'h70);
    run(2, 0);
    s_bus.tvalid[3] = 1'b1;
    s_bus.tdata[3*DW +: DW] = 8'h71;
    m_bus.tready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || m_bus.tdata !== 8'h71) begin errors++; $display("FAIL rstmid_beat2: got busy=%b data=%h want 1/71", busy, m_bus.tdata); end
    tick();
    checks++; if (m_bus.tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== '0 || m_tid !== '0 || s_bus.tready !== '0) begin
      errors++; $display("FAIL rstmid_state: got m_tvalid=%b busy=%b cnt=%0d tid=%0d s_tready=%b want 0/0/0/0/0000",
                         m_bus.tvalid, busy, pkt_cnt, m_tid, s_bus.tready);
    end
    rst = 1'b0;
    clear_engine();
    push_pkt(0, 2, 8'h80);
    run(20, 0);
    checks++; if (timed_out || rec_data.size() != 2 || rec_tid[0] != 0 || rec_data[0] !== 8'h80 || rec_data[1] !== 8'h81 || pkt_cnt !== 16'd1) begin
      errors++; $display("FAIL rstmid_after: got %0d beats cnt=%0d want 2 beats 80,81 from source 0, cnt 1", rec_data.size(), pkt_cnt);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_reset(); clear_engine();
      stall_en = 1'b1;
      rmode = 2;
      for (int s = 0; s < NS; s++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int p = 0; p < n; p++) push_pkt(s, $urandom_range(1, 5), -1);
      end
      build_model(0);
      run(3000, 0);
      checks++; if (timed_out || rec_data.size() != exp_data.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d beats timeout=%0d want %0d", round, rec_data.size(), timed_out, exp_data.size());
      end
      for (int k = 0; k < rec_data.size() && k < exp_data.size(); k++) begin
        checks++;
        if (rec_tid[k] != exp_tid[k] || rec_data[k] !== exp_data[k] || rec_last[k] != exp_last[k]) begin
          errors++; $display("FAIL rand%0d_beat%0d: got tid=%0d data=%h last=%0d want tid=%0d data=%h last=%0d",
                             round, k, rec_tid[k], rec_data[k], rec_last[k], exp_tid[k], exp_data[k], exp_last[k]);
        end
      end
      checks++; if (pkt_cnt !== CW'(model_pkts) || viol != 0) begin
        errors++; $display("FAIL rand%0d_status: got cnt=%0d viol=%0d want %0d/0", round, pkt_cnt, viol, model_pkts);
      end
    end
  endtask

  initial begin
    s_bus.tvalid = '0;
    s_bus.tlast = '0;
    s_bus.tdata = '0;
    m_bus.tready = 1'b0;
    test_reset();
    test_single_source();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_mask();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
